round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clk cycles per 100 ms tick (50 MHz clk); legal >= 2.
REQ-002 Parameter WARN_TENTHS, default 100, remaining-time threshold (tenths of a second) for the warning output.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  single-cycle pulse; begins a round from IDLE or DONE.
REQ-006 Port pause  input  1  single-cycle pulse; toggles RUN <-> PAUSE.
REQ-007 Port time_in  input  10  remaining time in tenths, from the countdown timer.
REQ-008 Port timer_stop  input  1  countdown timer's stop flag (aborted round).
REQ-009 Port timer_enable  output  1  enable to the countdown timer.
REQ-010 Port ms100  output  1  single-cycle 100 ms tick to the countdown timer.
REQ-011 Port running  output  1  high in RUN.
REQ-012 Port paused  output  1  high in PAUSE.
REQ-013 Port game_over  output  1  high in DONE.
REQ-014 Port warn  output  1  low-time warning.
REQ-015 Port round_count  output  4  completed rounds, saturating.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: timer_enable=0, ms100=0; start=1 -> RUN next cycle, prescaler cleared to 0, seen_tick cleared.
REQ-018 RUN: timer_enable=1; prescaler increments each cycle; at TICK_DIV-1 wraps to 0 and ms100=1 for exactly that one cycle; first ms100 = TICK_DIV cycles after RUN entry.
REQ-019 seen_tick flag set on the cycle ms100 is issued; held until next round start.
REQ-020 RUN -> DONE when (time_in==0 and seen_tick==1) or timer_stop==1; ms100 not issued on the transition cycle.
REQ-021 RUN, pause=1 and no DONE condition -> PAUSE; prescaler value held, not cleared.
REQ-022 PAUSE: timer_enable stays 1 (timer must not see enable drop), ms100=0, prescaler frozen; pause=1 -> RUN, resuming count from held value; timer_stop=1 -> DONE.
REQ-023 DONE: timer_enable=0, ms100=0, game_over=1; start=1 -> RUN with prescaler and seen_tick cleared.
REQ-024 round_count increments by 1 on each entry to DONE; saturates at 15, no wrap.
REQ-025 warn=1 in RUN or PAUSE when seen_tick==1 and 0 < time_in <= WARN_TENTHS; else 0.
REQ-026 Simultaneous start and pause in IDLE/DONE: start wins, pause ignored (round starts in RUN, not PAUSE).
REQ-027 Simultaneous pause and DONE condition in RUN: DONE wins.
REQ-028 start in RUN/PAUSE ignored; pause in IDLE/DONE ignored.
REQ-029 time_in==0 before seen_tick (timer not yet loaded) does not end the round.

Reset
REQ-030 rst=1 at a clock edge: state IDLE, prescaler 0, seen_tick 0, round_count 0, all outputs 0, regardless of state, overriding all other inputs that cycle.
REQ-031 Reset mid-RUN or mid-PAUSE drops timer_enable to 0 next cycle; no ms100 emitted while rst=1.

Verification (TICK_DIV=4, WARN_TENTHS=3)
REQ-032 rst, then start pulse -> running=1 and timer_enable=1 next cycle; ms100 pulses every 4 cycles, first on cycle 4 after RUN entry.
REQ-033 In RUN, pause at prescaler=2 -> paused=1, no ms100 for 20 cycles; pause again -> next ms100 exactly 2 cycles after resume.
REQ-034 Drive time_in 5,4,3,2,1,0 on successive ticks -> warn rises when time_in=3, DONE when time_in=0, game_over=1, timer_enable=0, round_count=1.
REQ-035 timer_stop=1 in PAUSE -> DONE next cycle, round_count increments; start and pause same cycle in DONE -> RUN, paused=0.
REQ-036 Complete 17 rounds -> round_count holds 15; assert rst mid-RUN -> all outputs 0 next cycle, round_count=0.

Source files
------------

// File: rtl/round_controller_if.sv
// -----------------------------------------------------------------------------
// round_controller_if
// Groups the control/status signals between a round controller and the logic
// that drives it (buttons and countdown timer).
//   start        : single-cycle pulse, begins a round
//   pause        : single-cycle pulse, toggles run/pause
//   time_in      : remaining time in tenths of a second, from the countdown timer
//   timer_stop   : countdown timer abort flag
//   timer_enable : enable to the countdown timer
//   ms100        : single-cycle 100 ms tick to the countdown timer
//   running      : round is counting
//   paused       : round is paused
//   game_over    : round has finished
//   warn         : low remaining time warning
//   round_count  : completed rounds, saturating at 15
// slave modport is the controller side; master modport is the driving side.
// -----------------------------------------------------------------------------
interface round_controller_if;
  logic       start;
  logic       pause;
  logic [9:0] time_in;
  logic       timer_stop;
  logic       timer_enable;
  logic       ms100;
  logic       running;
  logic       paused;
  logic       game_over;
  logic       warn;
  logic [3:0] round_count;

  modport slave (
    input  start, pause, time_in, timer_stop,
    output timer_enable, ms100, running, paused, game_over, warn, round_count
  );

  modport master (
    output start, pause, time_in, timer_stop,
    input  timer_enable, ms100, running, paused, game_over, warn, round_count
  );
endinterface

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
// Sequences a timed game round: IDLE -> RUN <-> PAUSE -> DONE -> RUN ...
// Generates the 100 ms tick for an external countdown timer, ends the round
// when that timer reaches zero (after it has seen at least one tick) or aborts,
// raises a low-time warning and counts completed rounds.
// Parameters:
//   TICK_DIV    : clk cycles per 100 ms tick (>= 2)
//   WARN_TENTHS : warning threshold on remaining time, in tenths
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : round_controller_if.slave (start/pause/time_in/timer_stop in,
//         timer_enable/ms100/running/paused/game_over/warn/round_count out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module round_controller #(
  parameter int TICK_DIV    = 5000000,
  parameter int WARN_TENTHS = 100
) (
  input  logic              clk,
  input  logic              rst,
  round_controller_if.slave bus
);

  localparam int          PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [31:0] WARN_U     = WARN_TENTHS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_seen_tick;
  logic [3:0]    r_round_count;
  logic          r_timer_enable;
  logic          r_ms100;
  logic          r_running;
  logic          r_paused;
  logic          r_game_over;
  logic          r_warn;

  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_seen_nxt;
  logic [3:0]    w_count_nxt;
  logic          w_ms100_nxt;
  logic          w_warn_nxt;
  logic          w_tick;
  logic          w_run_done;
  logic          w_warn_range;

  assign w_tick       = (r_presc == PRESC_LAST);
  // A zero time_in only means "expired" once the timer has been ticked; before
  // that it may simply not have been loaded yet.
  assign w_run_done   = ((bus.time_in == 10'd0) && r_seen_tick) || bus.timer_stop;
  assign w_warn_range = (bus.time_in != 10'd0) && ({22'd0, bus.time_in} <= WARN_U);

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_seen_nxt  = r_seen_tick;
    w_count_nxt = r_round_count;
    w_ms100_nxt = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        // start beats a coincident pause: a new round always begins counting.
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_presc_nxt = '0;
          w_seen_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (w_run_done) begin
          w_state_nxt = S_DONE;
        end else if (bus.pause) begin
          w_state_nxt = S_PAUSE;  // prescaler holds its value for the resume
        end else if (w_tick) begin
          w_presc_nxt = '0;
          w_ms100_nxt = 1'b1;
          w_seen_nxt  = 1'b1;
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (bus.timer_stop) begin
          w_state_nxt = S_DONE;
        end else if (bus.pause) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt == S_DONE) && (r_state != S_DONE) && (r_round_count != 4'hF)) begin
      w_count_nxt = r_round_count + 4'd1;
    end

    w_warn_nxt = ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE))
                 && w_seen_nxt && w_warn_range;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  // Status outputs are decoded from the next state so they are themselves flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_presc        <= '0;
      r_seen_tick    <= 1'b0;
      r_round_count  <= 4'd0;
      r_timer_enable <= 1'b0;
      r_ms100        <= 1'b0;
      r_running      <= 1'b0;
      r_paused       <= 1'b0;
      r_game_over    <= 1'b0;
      r_warn         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_presc        <= w_presc_nxt;
      r_seen_tick    <= w_seen_nxt;
      r_round_count  <= w_count_nxt;
      // The timer keeps its enable through PAUSE; only the tick stops.
      r_timer_enable <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
      r_ms100        <= w_ms100_nxt;
      r_running      <= (w_state_nxt == S_RUN);
      r_paused       <= (w_state_nxt == S_PAUSE);
      r_game_over    <= (w_state_nxt == S_DONE);
      r_warn         <= w_warn_nxt;
    end
  end

  assign bus.timer_enable = r_timer_enable;
  assign bus.ms100        = r_ms100;
  assign bus.running      = r_running;
  assign bus.paused       = r_paused;
  assign bus.game_over    = r_game_over;
  assign bus.warn         = r_warn;
  assign bus.round_count  = r_round_count;

endmodule

// File: tb/tb_round_controller.sv
// -----------------------------------------------------------------------------
// tb_round_controller
// Directed stimulus for round_controller with TICK_DIV=4, WARN_TENTHS=3.
// Stimulus pushes hand-computed output snapshots tagged with the clock cycle
// at which they must be visible; a separate monitor pops and compares them on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_round_controller;

  localparam int TICK_DIV    = 4;
  localparam int WARN_TENTHS = 3;

  typedef struct packed {
    logic       running;
    logic       paused;
    logic       game_over;
    logic       timer_enable;
    logic       ms100;
    logic       warn;
    logic [3:0] round_count;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int    exp_tag[$];
  obs_t  exp_val[$];
  string exp_name[$];

  round_controller_if bus();

  round_controller #(
    .TICK_DIV   (TICK_DIV),
    .WARN_TENTHS(WARN_TENTHS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(logic r, logic p, logic g, logic e, logic m, logic w, int n);
    obs_t o;
    o.running      = r;
    o.paused       = p;
    o.game_over    = g;
    o.timer_enable = e;
    o.ms100        = m;
    o.warn         = w;
    o.round_count  = 4'(n);
    return o;
  endfunction

  function automatic obs_t idle_s(int n);           return mk(0, 0, 0, 0, 0, 0, n); endfunction
  function automatic obs_t run_s(logic m, logic w, int n); return mk(1, 0, 0, 1, m, w, n); endfunction
  function automatic obs_t pau_s(logic w, int n);   return mk(0, 1, 0, 1, 0, w, n); endfunction
  function automatic obs_t done_s(int n);           return mk(0, 0, 1, 0, 0, 0, n); endfunction

  task automatic expect_at(int tag, obs_t v, string name);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
    exp_name.push_back(name);
  endtask

  task automatic check(string name, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got run,pau,go,en,ms,warn,cnt=%b,%b,%b,%b,%b,%b,%0d required %b,%b,%b,%b,%b,%b,%0d",
               name, cyc, got.running, got.paused, got.game_over, got.timer_enable, got.ms100,
               got.warn, got.round_count, exp.running, exp.paused, exp.game_over,
               exp.timer_enable, exp.ms100, exp.warn, exp.round_count);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: compares every snapshot due at the current cycle.
  initial begin
    obs_t got;
    forever begin
      @(negedge clk);
      got = {bus.running, bus.paused, bus.game_over, bus.timer_enable,
             bus.ms100, bus.warn, bus.round_count};
      while (exp_tag.size() > 0 && exp_tag[0] <= cyc) begin
        if (exp_tag[0] < cyc) begin
          total++;
          bad++;
          $display("FAIL %s: snapshot for cycle %0d missed (now %0d)", exp_name[0], exp_tag[0], cyc);
        end else begin
          check(exp_name[0], got, exp_val[0]);
        end
        void'(exp_tag.pop_front());
        void'(exp_val.pop_front());
        void'(exp_name.pop_front());
      end
    end
  end

  initial begin
    int c;
    int d;
    int x;
    int cnt;

    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.time_in    = 10'd50;
    bus.timer_stop = 1'b0;
    rst            = 1'b1;

    // Reset, then a pause pulse in IDLE must be ignored.
    step();
    expect_at(cyc + 1, idle_s(0), "reset_hold");
    step();
    rst = 1'b0;
    bus.pause = 1'b1;
    expect_at(cyc + 1, idle_s(0), "pause_ignored_idle");
    step();
    bus.pause = 1'b0;

    // Start: RUN next cycle, first tick 4 cycles after entry.
    c = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= 7; k++) expect_at(c + k, run_s(k == 5, 0, 0), "run_tick_cadence");
    step();
    bus.start = 1'b0;

    // Pause while the prescaler holds 2; 20 quiet cycles; resume.
    wait_until(c + 7);
    bus.pause = 1'b1;
    for (int k = 8; k <= 27; k++) expect_at(c + k, pau_s(0, 0), "paused_no_tick");
    step();
    bus.pause = 1'b0;
    wait_until(c + 27);
    bus.pause = 1'b1;
    expect_at(c + 28, run_s(0, 0, 0), "resume_run");
    expect_at(c + 29, run_s(0, 0, 0), "resume_run");
    expect_at(c + 30, run_s(1, 0, 0), "resume_tick_after_2");
    expect_at(c + 31, run_s(0, 0, 0), "resume_run");
    step();
    bus.pause = 1'b0;

    // Countdown 5..0 on successive ticks: warn from 3, DONE at 0.
    wait_until(c + 31);
    bus.time_in = 10'd5;
    for (int t = c + 32; t <= c + 50; t++)
      expect_at(t, run_s(((t - c - 34) % 4 == 0) && (t >= c + 34),
                         (t >= c + 39) && (t <= c + 50), 0), "countdown");
    expect_at(c + 51, done_s(1), "done_at_zero");
    expect_at(c + 52, done_s(1), "done_hold");
    for (int i = 0; i < 5; i++) begin
      wait_until(c + 34 + 4 * i);
      bus.time_in = 10'(4 - i);
    end

    // New round with time_in still 0: no end before the first tick.
    d = c + 52;
    wait_until(d);
    bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) expect_at(d + k, run_s(k == 5, 0, 1), "zero_before_tick");
    step();
    bus.start = 1'b0;
    wait_until(d + 3);
    bus.time_in = 10'd20;

    // Pause, then timer_stop while paused.
    wait_until(d + 5);
    bus.pause = 1'b1;
    expect_at(d + 6, pau_s(0, 1), "pause_again");
    expect_at(d + 7, pau_s(0, 1), "pause_again");
    step();
    bus.pause = 1'b0;
    wait_until(d + 7);
    bus.timer_stop = 1'b1;
    expect_at(d + 8, done_s(2), "stop_in_pause");
    step();
    bus.timer_stop = 1'b0;

    // start and pause together in DONE: start wins.
    bus.start = 1'b1;
    bus.pause = 1'b1;
    expect_at(d + 9, run_s(0, 0, 2), "start_beats_pause");
    step();
    bus.start = 1'b0;
    bus.pause = 1'b0;
    expect_at(d + 10, run_s(0, 0, 2), "run");
    step();
    bus.start = 1'b1;  // ignored in RUN
    expect_at(d + 11, run_s(0, 0, 2), "start_ignored_run");
    expect_at(d + 12, run_s(0, 0, 2), "start_ignored_run");
    step();
    bus.start = 1'b0;

    // Stop and pause on the would-be tick cycle: DONE wins, no tick.
    wait_until(d + 12);
    bus.timer_stop = 1'b1;
    bus.pause      = 1'b1;
    expect_at(d + 13, done_s(3), "done_beats_pause_no_tick");
    step();
    bus.timer_stop = 1'b0;
    bus.pause      = 1'b0;

    // Fourteen more short rounds: 17 in total, count saturates at 15.
    for (int i = 1; i <= 14; i++) begin
      x   = cyc;
      cnt = (3 + i > 15) ? 15 : 3 + i;
      bus.start = 1'b1;
      expect_at(x + 1, run_s(0, 0, (2 + i > 15) ? 15 : 2 + i), "short_round_run");
      step();
      bus.start      = 1'b0;
      bus.timer_stop = 1'b1;
      expect_at(x + 2, done_s(cnt), "round_count_sat");
      step();
      bus.timer_stop = 1'b0;
    end

    // Reset mid-RUN clears everything including the round count.
    x = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) expect_at(x + k, run_s(0, 0, 15), "run_before_reset");
    step();
    bus.start = 1'b0;
    wait_until(x + 3);
    rst = 1'b1;
    expect_at(x + 4, idle_s(0), "reset_mid_run");
    expect_at(x + 5, idle_s(0), "reset_held");
    step();
    step();
    rst = 1'b0;

    // Reset mid-PAUSE.
    x = cyc;
    bus.start = 1'b1;
    expect_at(x + 1, run_s(0, 0, 0), "run_after_reset");
    step();
    bus.start = 1'b0;
    bus.pause = 1'b1;
    expect_at(x + 2, pau_s(0, 0), "pause_before_reset");
    step();
    bus.pause = 1'b0;
    rst = 1'b1;
    expect_at(x + 3, idle_s(0), "reset_mid_pause");
    step();
    rst = 1'b0;
    expect_at(x + 4, idle_s(0), "idle_after_pause_reset");
    step();

    // Drain outstanding snapshots with a bounded wait.
    for (int i = 0; i < 50 && exp_tag.size() > 0; i++) step();
    step();
    while (exp_tag.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: snapshot for cycle %0d never compared", exp_name[0], exp_tag[0]);
      void'(exp_tag.pop_front());
      void'(exp_val.pop_front());
      void'(exp_name.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
